// File: rtl/text_menu_render.sv
// ---------------------------------------------------------------------------
// text_menu_render: up/down menu selection plus one scaled text line streamed
// from a synchronous font ROM. Optional macro MENU_WRAP_EN wraps the selection.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module text_menu_render #(
  parameter int ENTRIES = 3,
  parameter int CHARS   = 10,
  parameter int CORDW   = 16,
  parameter int SCALE   = 8,
  parameter int FONT_W  = 8,
  parameter int FONT_H  = 8,
  parameter int GLYPHS  = 64,
  parameter int TXT_X   = 204,
  parameter int TXT_Y   = 352,
  localparam int AW     = $clog2(GLYPHS*FONT_H),
  localparam int SW     = $clog2(ENTRIES)
) (
  input  logic                       clk_pix,
  input  logic                       rst_pix_n,
  input  logic                       btn_up,
  input  logic                       btn_dn,
  input  logic [ENTRIES*CHARS*8-1:0] titles,
  input  logic signed [CORDW-1:0]    sx,
  input  logic signed [CORDW-1:0]    sy,
  input  logic                       line,
  input  logic                       frame,
  input  logic                       de,
  output logic [AW-1:0]              font_rom_addr,
  input  logic [FONT_W-1:0]          font_rom_data,
  output logic [SW-1:0]              sel_idx,
  output logic                       sel_chg,
  output logic                       pix
);

  localparam int CW   = (CHARS > 1)  ? $clog2(CHARS)  : 1;
  localparam int RW   = (FONT_H > 1) ? $clog2(FONT_H) : 1;
  localparam int BW   = (FONT_W > 1) ? $clog2(FONT_W) : 1;
  localparam int SCL  = $clog2(SCALE);
  localparam int SPAN = CHARS*FONT_W*SCALE;
  localparam int BAND = FONT_H*SCALE;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     row_q, row_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [SW-1:0]     sel_next_q, sel_next_d;
  logic [SW-1:0]     sel_idx_q, sel_idx_d;
  logic              sel_chg_q, sel_chg_d;
  logic              up_q, dn_q;
  logic              pix_q, pix_d;
  logic [FONT_W-1:0] rowbuf_q [CHARS];

  logic                    w_up_rise, w_dn_rise;
  logic signed [CORDW-1:0] w_dy, w_dx;
  logic                    w_in_band, w_in_span;
  logic [RW-1:0]           w_row_new, w_row_sel;
  logic [CW-1:0]           w_fk;
  int                      w_char_base;
  logic [7:0]              w_char;
  logic [AW-1:0]           w_glyph, w_addr;
  logic                    w_buf_we;
  logic [CW-1:0]           w_buf_idx;
  logic [CORDW-1:0]        w_col;
  logic [CW-1:0]           w_kidx;
  logic [BW-1:0]           w_bidx;
  logic [FONT_W-1:0]       w_rowbits;

  // Selection: edge-detected buttons move sel_next; frame commits it.
  assign w_up_rise = btn_up & ~up_q;
  assign w_dn_rise = btn_dn & ~dn_q;

  always_comb begin
    sel_next_d = sel_next_q;
    if (w_up_rise && !w_dn_rise) begin
      if (sel_next_q == SW'(ENTRIES-1)) begin
`ifdef MENU_WRAP_EN
        sel_next_d = '0;
`else
        sel_next_d = sel_next_q;
`endif
      end else begin
        sel_next_d = sel_next_q + 1'b1;
      end
    end else if (w_dn_rise && !w_up_rise) begin
      if (sel_next_q == '0) begin
`ifdef MENU_WRAP_EN
        sel_next_d = SW'(ENTRIES-1);
`else
        sel_next_d = sel_next_q;
`endif
      end else begin
        sel_next_d = sel_next_q - 1'b1;
      end
    end
    sel_idx_d = frame ? sel_next_q : sel_idx_q;
    sel_chg_d = frame && (sel_next_q != sel_idx_q);
  end

  assign w_dy      = sy - CORDW'(TXT_Y);
  assign w_in_band = !w_dy[CORDW-1] && (w_dy < CORDW'(BAND));
  assign w_row_new = w_dy[SCL +: RW];
  assign w_row_sel = line ? w_row_new : row_q;

  // Character index for the address issued at the coming edge.
  always_comb begin
    w_fk = '0;
    if (!line && state_q == S_FETCH && cnt_q != CW'(CHARS-1)) begin
      w_fk = cnt_q + 1'b1;
    end
  end

  assign w_char_base = int'(sel_idx_q)*CHARS*8 + (CHARS - 1 - int'(w_fk))*8;
  assign w_char      = titles[w_char_base +: 8];

  always_comb begin
    w_glyph = '0;
    if (int'(w_char) >= 32 && int'(w_char) < 32 + GLYPHS) begin
      w_glyph = AW'(w_char - 8'h20);
    end
  end

  assign w_addr = w_glyph * AW'(FONT_H) + AW'(w_row_sel);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    addr_d    = '0;
    w_buf_we  = 1'b0;
    w_buf_idx = cnt_q - 1'b1;
    if (line) begin
      if (w_in_band) begin
        state_d = S_FETCH;
        cnt_d   = '0;
        row_d   = w_row_new;
        addr_d  = w_addr;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          w_buf_we = (cnt_q != '0);
          if (cnt_q == CW'(CHARS-1)) begin
            state_d = S_FLUSH;
          end else begin
            cnt_d  = cnt_q + 1'b1;
            addr_d = w_addr;
          end
        end
        S_FLUSH: begin
          w_buf_we  = 1'b1;
          w_buf_idx = CW'(CHARS-1);
          state_d   = S_READY;
        end
        default: ;
      endcase
    end
  end

  assign w_dx      = sx - CORDW'(TXT_X);
  assign w_in_span = !w_dx[CORDW-1] && (w_dx < CORDW'(SPAN));
  assign w_col     = $unsigned(w_dx) >> SCL;
  assign w_kidx    = w_in_span ? CW'(w_col / CORDW'(FONT_W)) : '0;
  assign w_bidx    = BW'(w_col % CORDW'(FONT_W));
  assign w_rowbits = rowbuf_q[w_kidx];
  assign pix_d     = (state_q == S_READY) && de && w_in_span &&
                     w_rowbits[BW'(FONT_W-1) - w_bidx];

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      sel_next_q <= '0;
      sel_idx_q  <= '0;
      sel_chg_q  <= 1'b0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      pix_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      sel_next_q <= sel_next_d;
      sel_idx_q  <= sel_idx_d;
      sel_chg_q  <= sel_chg_d;
      up_q       <= btn_up;
      dn_q       <= btn_dn;
      pix_q      <= pix_d;
    end
  end

  // Buffer contents only matter in READY, so they carry no reset.
  always_ff @(posedge clk_pix) begin
    if (w_buf_we) begin
      rowbuf_q[w_buf_idx] <= font_rom_data;
    end
  end

  assign font_rom_addr = addr_q;
  assign sel_idx       = sel_idx_q;
  assign sel_chg       = sel_chg_q;
  assign pix           = pix_q;

endmodule

`default_nettype wire
